uart_mem_bridge: RTL

Parametrised successor to the CPU-side UART memory link. Turns CPU load/store requests into byte-serial frames on a byte-stream TX/RX interface; the external byte UART is outside this block. Adds:
- configurable address/data widths
- a posted-write queue
- a read-response timeout with error reporting

Sits between the CPU memory stage and the byte UART pair.

---
 rtl/uart_mem_bridge.sv | 278 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/uart_mem_bridge.sv
// CPU load/store to byte-serial UART frame bridge with posted-write queue and read-response timeout.
// Define UART_MEM_BRIDGE_CHKSUM_EN to append/expect a trailing XOR checksum byte on every frame.
module uart_mem_bridge #(
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned WQ_DEPTH    = 4,
    parameter int unsigned TIMEOUT_CYC = 1000000
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        req_valid,
    output logic                        req_ready,
    input  logic                        req_write,
    input  logic [ADDR_W-1:0]           req_addr,
    input  logic [DATA_W-1:0]           req_wdata,
    input  logic [DATA_W/8-1:0]         req_mask,
    input  logic [2:0]                  req_size,
    output logic                        rsp_valid,
    output logic [DATA_W-1:0]           rsp_rdata,
    output logic                        rsp_error,
    output logic [7:0]                  tx_data,
    output logic                        tx_valid,
    input  logic                        tx_ready,
    input  logic [7:0]                  rx_data,
    input  logic                        rx_valid,
    output logic [$clog2(WQ_DEPTH):0]   wq_level,
    output logic                        busy
);
    localparam int unsigned AB    = ADDR_W / 8;
    localparam int unsigned DB    = DATA_W / 8;
    localparam int unsigned MW    = DATA_W / 8;
    localparam int unsigned PTR_W = $clog2(WQ_DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;
    localparam int unsigned CNT_W = 4;
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYC) + 1;
`ifdef UART_MEM_BRIDGE_CHKSUM_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif
    localparam int unsigned RXB = DB + (CHK ? 1 : 0);

    typedef enum logic [2:0] {
        IDLE, TX_OP, TX_ADDR, TX_ATTR, TX_DATA, TX_CHK, RX_DATA, RESP
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [TMO_W-1:0]   tmo_q, tmo_d;
    logic               run_q;

    logic [ADDR_W-1:0]  q_addr [WQ_DEPTH];
    logic [DATA_W-1:0]  q_data [WQ_DEPTH];
    logic [MW-1:0]      q_mask [WQ_DEPTH];
    logic [PTR_W-1:0]   wr_ptr, rd_ptr;
    logic [LVL_W-1:0]   level;
    logic               q_empty, q_full, push, pop;

    logic               cur_write;
    logic [ADDR_W-1:0]  addr_sh;
    logic [DATA_W-1:0]  data_sh;
    logic [MW-1:0]      cur_mask;
    logic [2:0]         cur_size;
    logic [7:0]         chk_q;
    logic [DATA_W-1:0]  rx_asm, asm_d;
    logic [7:0]         rx_chk;

    logic               tx_fire, load_wq, load_rd, rx_start, rx_take, rsp_go, rsp_err_d;

    assign q_empty   = (level == '0);
    assign q_full    = (level == LVL_W'(WQ_DEPTH));
    assign req_ready = run_q && (req_write ? !q_full : (q_empty && state_q == IDLE));
    assign push      = req_valid && req_ready && req_write;
    assign wq_level  = level;
    assign busy      = (state_q != IDLE) || !q_empty;
    assign tx_fire   = tx_valid && tx_ready;

    // Byte presented to the UART is a pure decode of the frame registers, so it holds under backpressure
    always_comb begin
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        unique case (state_q)
            TX_OP: begin
                tx_valid = 1'b1;
                tx_data  = cur_write ? 8'hA5 : 8'h5A;
            end
            TX_ADDR: begin
                tx_valid = 1'b1;
                tx_data  = addr_sh[7:0];
            end
            TX_ATTR: begin
                tx_valid = 1'b1;
                tx_data  = cur_write ? 8'(cur_mask) : {5'b0, cur_size};
            end
            TX_DATA: begin
                tx_valid = 1'b1;
                tx_data  = data_sh[7:0];
            end
            TX_CHK: begin
                tx_valid = 1'b1;
                tx_data  = chk_q;
            end
            default: ;
        endcase
    end

    // Next-state and per-cycle control
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        tmo_d     = tmo_q;
        load_wq   = 1'b0;
        load_rd   = 1'b0;
        pop       = 1'b0;
        rx_start  = 1'b0;
        rx_take   = 1'b0;
        rsp_go    = 1'b0;
        rsp_err_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (!q_empty) begin
                    load_wq = 1'b1;
                    state_d = TX_OP;
                end else if (req_valid && req_ready && !req_write) begin
                    load_rd = 1'b1;
                    state_d = TX_OP;
                end
            end
            TX_OP: if (tx_fire) begin
                state_d = TX_ADDR;
                cnt_d   = '0;
            end
            TX_ADDR: if (tx_fire) begin
                if (cnt_q == CNT_W'(AB - 1)) begin
                    state_d = TX_ATTR;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            TX_ATTR: if (tx_fire) begin
                cnt_d = '0;
                if (cur_write) begin
                    state_d = TX_DATA;
                end else if (CHK) begin
                    state_d = TX_CHK;
                end else begin
                    state_d  = RX_DATA;
                    tmo_d    = '0;
                    rx_start = 1'b1;
                end
            end
            TX_DATA: if (tx_fire) begin
                if (cnt_q == CNT_W'(DB - 1)) begin
                    cnt_d = '0;
                    if (CHK) begin
                        state_d = TX_CHK;
                    end else begin
                        state_d = IDLE;
                        pop     = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            TX_CHK: if (tx_fire) begin
                cnt_d = '0;
                if (cur_write) begin
                    state_d = IDLE;
                    pop     = 1'b1;
                end else begin
                    state_d  = RX_DATA;
                    tmo_d    = '0;
                    rx_start = 1'b1;
                end
            end
            RX_DATA: begin
                if (rx_valid) begin
                    tmo_d   = '0;
                    rx_take = 1'b1;
                    if (cnt_q == CNT_W'(RXB - 1)) begin
                        state_d   = RESP;
                        rsp_go    = 1'b1;
                        rsp_err_d = CHK && (rx_data != rx_chk);
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end else if (tmo_q == TMO_W'(TIMEOUT_CYC - 1)) begin
                    state_d   = RESP;
                    rsp_go    = 1'b1;
                    rsp_err_d = 1'b1;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            RESP: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Read data assembly, including the byte arriving this cycle so RESP sees the full word
    always_comb begin
        asm_d = rx_asm;
        if (rx_take) begin
            for (int i = 0; i < int'(DB); i++) begin
                if (cnt_q == CNT_W'(i)) asm_d[i*8 +: 8] = rx_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            q_addr[wr_ptr] <= req_addr;
            q_data[wr_ptr] <= req_wdata;
            q_mask[wr_ptr] <= req_mask;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            tmo_q     <= '0;
            run_q     <= 1'b0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level     <= '0;
            cur_write <= 1'b0;
            addr_sh   <= '0;
            data_sh   <= '0;
            cur_mask  <= '0;
            cur_size  <= '0;
            chk_q     <= '0;
            rx_asm    <= '0;
            rx_chk    <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_error <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tmo_q   <= tmo_d;
            run_q   <= 1'b1;
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            level <= level + LVL_W'(push) - LVL_W'(pop);
            if (load_wq) begin
                cur_write <= 1'b1;
                addr_sh   <= q_addr[rd_ptr];
                data_sh   <= q_data[rd_ptr];
                cur_mask  <= q_mask[rd_ptr];
                chk_q     <= '0;
            end else if (load_rd) begin
                cur_write <= 1'b0;
                addr_sh   <= req_addr;
                cur_size  <= req_size;
                chk_q     <= '0;
            end else if (tx_fire) begin
                chk_q <= chk_q ^ tx_data;
                if (state_q == TX_ADDR) addr_sh <= addr_sh >> 8;
                if (state_q == TX_DATA) data_sh <= data_sh >> 8;
            end
            if (rx_start) begin
                rx_asm <= '0;
                rx_chk <= '0;
            end else if (rx_take) begin
                rx_asm <= asm_d;
                if (cnt_q < CNT_W'(DB)) rx_chk <= rx_chk ^ rx_data;
            end
            rsp_valid <= rsp_go;
            if (rsp_go) begin
                rsp_rdata <= rsp_err_d ? '0 : asm_d;
                rsp_error <= rsp_err_d;
            end
        end
    end
endmodule
